// File: rtl/accumulator_bank.sv
// accumulator_bank: captures one DEPTH-entry product row (overwrite or accumulate per write),
// then drains it over a valid/ready port. Define ACCUMULATOR_BANK_SATURATE_EN for signed saturating accumulate.
module accumulator_bank #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       in_accum,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(DEPTH)-1:0]   out_index,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

   typedef enum logic {FILL, DRAIN} state_t;
   state_t state, next_state;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic              wr_en, rd_en;

   assign wr_en = (state == FILL) && in_valid;
   assign rd_en = (state == DRAIN) && out_ready;

   function automatic logic [DATA_W-1:0] acc_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef ACCUMULATOR_BANK_SATURATE_EN
      logic [DATA_W-1:0] s;
      s = a + b;
      // Overflow only when both operands share a sign that the sum lost.
      if ((a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]))
         s = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      return s;
`else
      return a + b;
`endif
   endfunction

   always_ff @(posedge clk) begin
      if (!reset || clear) state <= FILL;
      else                 state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         FILL:  if (wr_en && wr_idx == LAST) next_state = DRAIN;
         DRAIN: if (rd_en && rd_idx == LAST) next_state = FILL;
         default: next_state = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_idx <= '0;
         rd_idx <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_idx] <= in_accum ? acc_add(mem[wr_idx], in_data) : in_data;
            wr_idx      <= (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
            count       <= count + 1'b1;
         end
         // Entries persist after the drain so the next pass can accumulate onto them.
         if (rd_en) begin
            if (rd_idx == LAST) begin
               rd_idx <= '0;
               wr_idx <= '0;
               count  <= '0;
            end else begin
               rd_idx <= rd_idx + 1'b1;
            end
         end
      end
   end

   assign in_ready  = (state == FILL);
   assign out_valid = (state == DRAIN);
   assign full      = (state == DRAIN);
   assign out_data  = mem[rd_idx];
   assign out_index = rd_idx;
endmodule

// File: tb/tb_accumulator_bank.sv
// Scoreboard bench for accumulator_bank (DEPTH=4, DATA_W=32): stimulus pushes expected drain words,
// a negedge monitor compares whatever the DUT presents against the queue head.
module tb_accumulator_bank;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;

   typedef struct packed {
      logic [1:0]        idx;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic              clk = 0;
   logic              reset, clear, in_valid, in_accum, out_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_ready, out_valid, full;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        out_index;
   logic [2:0]        count;

   exp_t q[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;

   accumulator_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_accum(in_accum),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
      .full(full), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Peek on every valid word (stall stability), pop on handshake.
   always @(negedge clk) begin
      if (out_valid === 1'b1 && q.size() > 0) begin
         chk("drain_index", {30'd0, out_index}, {30'd0, q[0].idx});
         chk("drain_data", out_data, q[0].data);
         if (out_ready) void'(q.pop_front());
      end else if (out_valid === 1'b1 && out_ready && q.size() == 0) begin
         chk("unexpected_word", {30'd0, out_index}, 32'hFFFF_FFFF);
      end
   end

   task automatic fill(input logic [31:0] d [4], input logic [3:0] acc);
      for (int i = 0; i < 4; i++) begin
         chk("in_ready_fill", {31'd0, in_ready}, 32'd1);
         in_valid = 1; in_data = d[i]; in_accum = acc[i];
         cyc();
      end
      in_valid = 0;
      chk("full_after_fill", {31'd0, full}, 32'd1);
      chk("count_full", {29'd0, count}, 32'd4);
      chk("out_valid_first", {31'd0, out_valid}, 32'd1);
      chk("in_ready_drain", {31'd0, in_ready}, 32'd0);
   endtask

   task automatic push4(input logic [31:0] e [4]);
      for (int i = 0; i < 4; i++) q.push_back('{idx: 2'(i), data: e[i]});
   endtask

   task automatic drain(input logic [31:0] e [4]);
      push4(e);
      out_ready = 1;
      repeat (DEPTH) cyc();
      out_ready = 0;
      chk("full_after_drain", {31'd0, full}, 32'd0);
      chk("count_after_drain", {29'd0, count}, 32'd0);
      chk("in_ready_after_drain", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      logic [5:0] pat;
      reset = 0; clear = 0; in_valid = 1; in_data = 32'd55; in_accum = 0; out_ready = 0;
      cyc(); cyc();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_count", {29'd0, count}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_index", {30'd0, out_index}, 32'd0);
      reset = 1; in_valid = 0;
      cyc();

      // Overwrite, then accumulate, then mixed overwrite/accumulate.
      fill('{5, 0, 7, 9}, 4'b0000);
      drain('{5, 0, 7, 9});
      fill('{1, 2, 3, 4}, 4'b1111);
      drain('{6, 2, 10, 13});
      fill('{10, 0, 0, 0}, 4'b1110);

      // Backpressure with a stray write attempt during drain.
      push4('{10, 2, 10, 13});
      pat = 6'b111001;
      in_valid = 1; in_data = 32'd99; in_accum = 0;
      for (int i = 0; i < 6; i++) begin
         out_ready = pat[i];
         chk("in_ready_bp", {31'd0, in_ready}, 32'd0);
         cyc();
      end
      in_valid = 0; out_ready = 0;
      chk("full_after_bp", {31'd0, full}, 32'd0);
      fill('{0, 0, 0, 0}, 4'b1111);
      drain('{10, 2, 10, 13});

      // Overflow behaviour.
      fill('{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 0}, 4'b0000);
      drain('{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 0});
      fill('{1, 32'hFFFF_FFFF, 2, 0}, 4'b1111);
`ifdef ACCUMULATOR_BANK_SATURATE_EN
      drain('{32'h7FFF_FFFF, 32'h8000_0000, 1, 0});
`else
      drain('{32'h8000_0000, 32'h7FFF_FFFF, 1, 0});
`endif

      // Clear after the second drained word.
      fill('{1, 2, 3, 4}, 4'b0000);
      q.push_back('{idx: 2'd0, data: 32'd1});
      q.push_back('{idx: 2'd1, data: 32'd2});
      out_ready = 1;
      cyc(); cyc();
      out_ready = 0; clear = 1;
      cyc();
      clear = 0;
      chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
      chk("clr_full", {31'd0, full}, 32'd0);
      chk("clr_count", {29'd0, count}, 32'd0);
      chk("clr_out_index", {30'd0, out_index}, 32'd0);
      chk("clr_out_data", out_data, 32'd0);
      fill('{0, 0, 0, 0}, 4'b1111);
      drain('{0, 0, 0, 0});

      // Reset after two fill writes.
      in_valid = 1; in_accum = 0; in_data = 32'd5; cyc();
      in_data = 32'd6; cyc();
      in_valid = 0;
      chk("count_mid_fill", {29'd0, count}, 32'd2);
      reset = 0;
      cyc();
      reset = 1;
      chk("rst2_count", {29'd0, count}, 32'd0);
      chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
      fill('{7, 8, 9, 10}, 4'b1111);
      drain('{7, 8, 9, 10});

      cyc(); cyc();
      chk("scoreboard_empty", q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
